divider_restoring: RTL and testbench
====================================

# divider_restoring

Sequential unsigned restoring divider. It is the inverse counterpart to the combinational carry-save multiplier and is used for mantissa/scale division in the floating-point datapath. It computes an N-bit quotient and an N-bit remainder at one quotient bit per clock, MSB first, with a start/done handshake.

## Interface

Parameters:
- `N`, default 4: operand, quotient and remainder width in bits; must be ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a division; accepted only when `busy` = 0.
- `a`, input, N: dividend, unsigned; sampled on the accepting edge.
- `b`, input, N: divisor, unsigned; sampled on the accepting edge.
- `q`, output, N: quotient, registered.
- `r`, output, N: remainder, registered.
- `busy`, output, 1: high while an operation is iterating.
- `done`, output, 1: one-cycle pulse; `q`, `r` and `div_by_zero` are valid from this cycle onward.
- `div_by_zero`, output, 1: high when the completed operation had `b` == 0; registered.

## Operation

- States:
  - IDLE: waiting for a request.
  - RUN: iterating for N cycles.
  - DONE: single result cycle.
- IDLE → RUN on `start` = 1. The accepting edge does the following:
  - latches `a` into the dividend shift register and `b` into the divisor register;
  - clears the (N+1)-bit partial remainder;
  - loads the iteration counter with N-1.
- Each RUN cycle:
  - shifts the partial remainder left by 1 and shifts in the dividend MSB;
  - trial subtracts the divisor, zero-extended to N+1 bits;
  - if the result is non-negative, keeps it and shifts a quotient bit 1 into the LSB;
  - otherwise restores the partial remainder and shifts in 0;
  - decrements the counter.
- RUN → DONE on the edge that completes the iteration with counter == 0.
- In DONE:
  - `done` = 1;
  - `q` = floor(a/b);
  - `r` = a mod b, taken from the low N bits of the partial remainder;
  - `div_by_zero` = (latched b == 0).
- DONE → IDLE unconditionally, or DONE → RUN if `start` = 1 in the DONE cycle, since `busy` is already low there. Back-to-back operations therefore issue every N+1 cycles.
- Divide by zero is not special-cased in the datapath. The restoring algorithm naturally yields `q` = 2^N−1 and `r` = a. The latency is the normal one, and the flag is set.
- `start` while `busy` = 1 is ignored; the in-flight operation and its operands are unaffected.
- Operand changes on `a`/`b` after the accepting edge have no effect.
- `q`, `r` and `div_by_zero` hold their last result until the next operation's DONE. They do not change during RUN.

## Timing

- Latency: `start` is accepted at edge E0.
  - `busy` = 1 after edges E0 through E(N−1).
  - The Nth iteration occurs at edge EN.
  - `done` = 1 for exactly the cycle following EN, i.e. N+1 cycles after acceptance.
- `busy` and `done` are never high simultaneously.
- Reset values, applied asynchronously on `rst` assertion:
  - state IDLE;
  - `q` = 0, `r` = 0;
  - `busy` = 0, `done` = 0, `div_by_zero` = 0;
  - counter and internal registers 0.
- Reset mid-RUN or in DONE aborts the operation. No `done` pulse is produced and outputs clear to 0 immediately.
- The first `start` after `rst` deasserts is accepted on the first rising edge at which it is seen high.
- Width rules:
  - internal partial remainder is N+1 bits;
  - the trial subtract uses N+1 bits and checks its MSB for sign;
  - there is no overflow, because `r` < `b` ≤ 2^N−1 always fits in N bits.

## Test plan

- N=4, a=15, b=4, single start pulse:
  - `busy` is high for 4 cycles;
  - `done` pulses in cycle 5;
  - `q`=3, `r`=3, `div_by_zero`=0.
- N=4, exhaustive sweep of all 256 (a, b) pairs:
  - every `done` has `q` == a/b and `r` == a%b for b≠0;
  - for b=0, `q`=15, `r`=a, `div_by_zero`=1;
  - `done` always arrives exactly 5 cycles after acceptance.
- Edge operands, N=4:
  - 0/5 gives q=0, r=0;
  - 15/1 gives q=15, r=0;
  - 15/15 gives q=1, r=0;
  - 7/8 gives q=0, r=7.
- Handshake:
  - pulse `start` with a=9, b=2;
  - reassert `start` with a=1, b=1 during RUN, and change `a`/`b` mid-operation;
  - the result must be q=4, r=1, and only one `done` pulse occurs;
  - then hold `start` high with a=12, b=5 through the DONE cycle: the next operation is accepted there, and the following `done` comes N+1 cycles later with q=2, r=2.
- Reset:
  - assert `rst` asynchronously two cycles into RUN of 14/3;
  - all outputs go to 0 without waiting for a clock edge, and no `done` is produced;
  - after release, 14/3 completes normally with q=4, r=2.
- Parameter N=8, random vectors:
  - 20 random (a, b) pairs with nonzero b, each checked against `/` and `%`;
  - latency is exactly 9 cycles for each;
  - 255/0 gives q=255, r=255, `div_by_zero`=1.

Source files
------------

// File: rtl/divider_restoring.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB
// first, start/done handshake. Divide-by-zero runs through the normal
// datapath (q = all ones, r = a) and raises div_by_zero.
module divider_restoring #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [N-1:0]   dvd;        // dividend bits shift out MSB-first, quotient bits shift in at LSB
    logic [N-1:0]   dvs;        // latched divisor
    logic [N:0]     prem;       // partial remainder
    logic [CW-1:0]  cnt;        // iterations remaining minus one

    logic [N:0]     shifted;
    logic [N:0]     diff;
    logic [N:0]     prem_nxt;
    logic [N-1:0]   dvd_nxt;
    logic           accept;

    // A request is taken whenever no iteration is in flight (IDLE or DONE)
    assign accept = start && (state != S_RUN);
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN:  if (cnt == '0) state_nxt = S_DONE;
            S_DONE: state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One restoring step: shift in dividend MSB, trial subtract, keep or restore
    always_comb begin
        shifted = {prem[N-1:0], dvd[N-1]};
        diff    = shifted - {1'b0, dvs};
        if (diff[N]) begin
            prem_nxt = shifted;
            dvd_nxt  = {dvd[N-2:0], 1'b0};
        end else begin
            prem_nxt = diff;
            dvd_nxt  = {dvd[N-2:0], 1'b1};
        end
    end

    // Datapath registers; results are published only on the final iteration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd         <= '0;
            dvs         <= '0;
            prem        <= '0;
            cnt         <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dvd  <= a;
            dvs  <= b;
            prem <= '0;
            cnt  <= CW'(N - 1);
        end else if (state == S_RUN) begin
            dvd  <= dvd_nxt;
            prem <= prem_nxt;
            cnt  <= cnt - CW'(1);
            if (cnt == '0) begin
                q           <= dvd_nxt;
                r           <= prem_nxt[N-1:0];
                div_by_zero <= (dvs == '0);
            end
        end
    end

endmodule

// File: tb/tb_divider_restoring.sv
// Self-checking bench for divider_restoring at N=4 and N=8.
module tb_divider_restoring;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start8;
    logic [3:0] a4, b4, q4, r4;
    logic [7:0] a8, b8, q8, r8;
    logic       busy4, done4, dbz4;
    logic       busy8, done8, dbz8;

    int tests = 0;
    int fails = 0;

    divider_restoring #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .q(q4), .r(r4), .busy(busy4), .done(done4), .div_by_zero(dbz4)
    );

    divider_restoring #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .q(q8), .r(r8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division; b == 0 yields all ones and the dividend
    function automatic void ref_div(input int n, input int av, input int bv,
                                    output int qv, output int rv, output int zv);
        if (bv == 0) begin
            qv = (1 << n) - 1;
            rv = av;
            zv = 1;
        end else begin
            qv = av / bv;
            rv = av % bv;
            zv = 0;
        end
    endfunction

    // Issue one operation and wait (bounded) for done; leaves the DUT back in IDLE
    task automatic run_op(input bit w8, input logic [7:0] av, input logic [7:0] bv,
                          output logic [7:0] qv, output logic [7:0] rv, output logic zv,
                          output int lat, output int bcyc, output int ovl, output bit got);
        if (w8) begin a8 = av; b8 = bv; start8 = 1'b1; end
        else begin a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1; end
        @(posedge clk); #1;
        start4 = 1'b0;
        start8 = 1'b0;
        lat = 0; bcyc = 0; ovl = 0; got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if ((w8 ? busy8 : busy4) && (w8 ? done8 : done4)) ovl++;
            if (w8 ? done8 : done4) begin
                got = 1'b1;
            end else begin
                if (w8 ? busy8 : busy4) bcyc++;
                @(posedge clk); #1;
                lat++;
            end
        end
        qv = w8 ? q8 : {4'b0, q4};
        rv = w8 ? r8 : {4'b0, r4};
        zv = w8 ? dbz8 : dbz4;
        if (got) begin @(posedge clk); #1; end
    endtask

    task automatic check_op(input string tag, input bit w8, input int av, input int bv,
                            input int eq, input int er, input int ez);
        logic [7:0] qv, rv;
        logic zv;
        int lat, bcyc, ovl, n;
        bit got;
        n = w8 ? 8 : 4;
        run_op(w8, 8'(av), 8'(bv), qv, rv, zv, lat, bcyc, ovl, got);
        chk($sformatf("%s %0d/%0d done_seen", tag, av, bv), 32'(got), 1);
        chk($sformatf("%s %0d/%0d q", tag, av, bv), 32'(qv), 32'(eq));
        chk($sformatf("%s %0d/%0d r", tag, av, bv), 32'(rv), 32'(er));
        chk($sformatf("%s %0d/%0d dbz", tag, av, bv), 32'(zv), 32'(ez));
        chk($sformatf("%s %0d/%0d latency", tag, av, bv), 32'(lat), 32'(n));
        chk($sformatf("%s %0d/%0d busy_cycles", tag, av, bv), 32'(bcyc), 32'(n));
        chk($sformatf("%s %0d/%0d busy_done_overlap", tag, av, bv), 32'(ovl), 0);
    endtask

    task automatic model_op(input string tag, input bit w8, input int av, input int bv);
        int eq, er, ez;
        ref_div(w8 ? 8 : 4, av, bv, eq, er, ez);
        check_op(tag, w8, av, bv, eq, er, ez);
    endtask

    vec_t vecs[6];
    int   ndone;

    initial begin
        rst = 1'b1;
        start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        #1;
        chk("reset q4", 32'(q4), 0);
        chk("reset r4", 32'(r4), 0);
        chk("reset busy4", 32'(busy4), 0);
        chk("reset done4", 32'(done4), 0);
        chk("reset dbz4", 32'(dbz4), 0);
        chk("reset busy8", 32'(busy8), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors with hand-computed expectations
        vecs[0] = '{a: 4'd15, b: 4'd4,  q: 4'd3,  r: 4'd3, z: 1'b0};
        vecs[1] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, z: 1'b0};
        vecs[2] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0};
        vecs[3] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0};
        vecs[4] = '{a: 4'd7,  b: 4'd8,  q: 4'd0,  r: 4'd7, z: 1'b0};
        vecs[5] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9, z: 1'b1};
        foreach (vecs[i])
            check_op("vec", 1'b0, int'(vecs[i].a), int'(vecs[i].b),
                     int'(vecs[i].q), int'(vecs[i].r), int'(vecs[i].z));

        // Exhaustive N=4 sweep against the reference model
        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                model_op("sweep", 1'b0, ai, bi);

        // Handshake: ignored start during RUN, operand changes, accept in DONE
        check_op("pre", 1'b0, 13, 5, 2, 3, 0);
        a4 = 4'd9; b4 = 4'd2; start4 = 1'b1;
        @(posedge clk); #1;                         // E0
        a4 = 4'd1; b4 = 4'd1; ndone = 0;
        @(posedge clk); #1; ndone += int'(done4);   // E1
        a4 = 4'd3; b4 = 4'd7;
        chk("hs q held in RUN", 32'(q4), 2);
        chk("hs r held in RUN", 32'(r4), 3);
        @(posedge clk); #1; ndone += int'(done4);   // E2
        start4 = 1'b0;
        @(posedge clk); #1; ndone += int'(done4);   // E3
        chk("hs busy E3", 32'(busy4), 1);
        start4 = 1'b1; a4 = 4'd12; b4 = 4'd5;
        @(posedge clk); #1; ndone += int'(done4);   // E4
        chk("hs done E4", 32'(done4), 1);
        chk("hs q 9/2", 32'(q4), 4);
        chk("hs r 9/2", 32'(r4), 1);
        chk("hs done count", 32'(ndone), 1);
        @(posedge clk); #1;                         // E5: accepted in DONE
        start4 = 1'b0;
        chk("hs busy after DONE accept", 32'(busy4), 1);
        chk("hs done low after DONE", 32'(done4), 0);
        chk("hs q held next op", 32'(q4), 4);
        ndone = 0;
        repeat (3) begin @(posedge clk); #1; ndone += int'(done4); end
        chk("hs no early done", 32'(ndone), 0);
        @(posedge clk); #1;                         // E9
        chk("hs done E9", 32'(done4), 1);
        chk("hs q 12/5", 32'(q4), 2);
        chk("hs r 12/5", 32'(r4), 2);
        @(posedge clk); #1;

        // Asynchronous reset two cycles into RUN
        a4 = 4'd14; b4 = 4'd3; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        chk("rst q4 async", 32'(q4), 0);
        chk("rst r4 async", 32'(r4), 0);
        chk("rst busy4 async", 32'(busy4), 0);
        chk("rst done4 async", 32'(done4), 0);
        chk("rst dbz4 async", 32'(dbz4), 0);
        ndone = 0;
        repeat (6) begin @(posedge clk); #1; ndone += int'(done4); end
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; ndone += int'(done4); end
        chk("rst no done", 32'(ndone), 0);
        check_op("post-rst", 1'b0, 14, 3, 4, 2, 0);

        // N=8 random vectors with nonzero divisor, then divide by zero
        for (int i = 0; i < 20; i++)
            model_op("rand8", 1'b1, int'($urandom_range(0, 255)), int'($urandom_range(1, 255)));
        check_op("n8", 1'b1, 255, 0, 255, 255, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
